alu_iter: RTL and testbench

Parametrised, multi-cycle execute unit that generalises the single-cycle ALU to XLEN bits. It adds the RV32M/RV64M multiply/divide operations on an iterative datapath and uses a valid/ready handshake on both sides. It sits in the execute stage and stalls the pipeline through `in_ready` while a long operation runs. Base ALU ops complete in one cycle; multiply and divide take XLEN+1 cycles.

---
 rtl/alu_iter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter -- multi-cycle execute unit: single-cycle base ALU plus an
// optional iterative RV32M/RV64M multiply/divide datapath, with valid/ready
// handshakes on the request and result sides.
//
// Build option:
//   ALU_ITER_MULDIV_EN  defined   : shift-add multiplier, restoring divider,
//                                   iteration counter and BUSY state built.
//                       undefined : every m_sel=1 op finishes in one cycle
//                                   with result=0 and out_illegal=1.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  request handshake (in_ready=0 while BUSY or flush)
//   m_sel                0: base op on operation, 1: M op on operation[2:0]
//   operation            ALU_* code (base) or RISC-V funct3 (M ops)
//   operand_a/operand_b  XLEN-bit sources
//   flush                abandon any in-flight or held result
//   out_valid/out_ready  result handshake
//   result, result_zero  registered result and its zero flag
//   out_illegal          op was not executable in this build
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package alu_iter_pkg;
  // Base ALU op codes.
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;
  localparam logic [3:0] ALU_SEQ  = 4'd11;

  // RISC-V M-extension funct3 codes.
  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            m_sel,
  input  logic [3:0]      operation,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            result_zero,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  state_t state_q, state_d;
  logic   accept;
  logic   long_op;  // accepted op needs the iterative datapath

  assign in_ready    = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == ST_DONE);
  assign result_zero = (result == '0);

  // -------------------------------------------------------------------------
  // Base ALU
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] base_res;
  logic [SHW-1:0]  shamt;

  assign shamt = operand_b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    base_res = '0;
    case (operation)
      ALU_ADD:  base_res = operand_a + operand_b;
      ALU_SUB:  base_res = operand_a - operand_b;
      ALU_SLL:  base_res = operand_a << shamt;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      ALU_XOR:  base_res = operand_a ^ operand_b;
      ALU_SRL:  base_res = operand_a >> shamt;
      ALU_SRA:  base_res = $signed(operand_a) >>> shamt;
      ALU_OR:   base_res = operand_a | operand_b;
      ALU_AND:  base_res = operand_a & operand_b;
      ALU_SEQ:  base_res = {{(XLEN-1){1'b0}}, (operand_a == operand_b)};
      default:  base_res = '0;  // ALU_NONE and unknown codes
    endcase
  end

`ifdef ALU_ITER_MULDIV_EN
  // -------------------------------------------------------------------------
  // Multiply/divide operand preparation (on accept)
  // -------------------------------------------------------------------------
  localparam int CW = $clog2(XLEN + 1);

  logic [2:0]      f3;
  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] ma, mb;
  logic            is_div, div_zero, div_ovf, div_fast;
  logic [XLEN-1:0] fast_res;

  assign f3 = operation[2:0];

  always_comb begin
    is_div   = f3[2];
    a_signed = (f3 != M_MULHU) && (f3 != M_DIVU) && (f3 != M_REMU);
    b_signed = a_signed && (f3 != M_MULHSU);
    sa       = a_signed && operand_a[XLEN-1];
    sb       = b_signed && operand_b[XLEN-1];
    ma       = sa ? ('0 - operand_a) : operand_a;
    mb       = sb ? ('0 - operand_b) : operand_b;
    div_zero = (operand_b == '0);
    // Only DIV/REM (funct3[0]=0) can overflow: most-negative / -1.
    div_ovf  = !f3[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    div_fast = is_div && (div_zero || div_ovf);
    if (div_zero) fast_res = f3[1] ? operand_a : '1;
    else          fast_res = f3[1] ? '0 : operand_a;
  end

  assign long_op = m_sel && !div_fast;

  // -------------------------------------------------------------------------
  // Iterative datapath. p_q holds {acc, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide; d_q is the multiplicand or
  // divisor magnitude.
  // -------------------------------------------------------------------------
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] p_q;
  logic [XLEN-1:0]   d_q;
  logic              neg_q;
  logic [2:0]        op_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] p_step, mul_full;
  logic [XLEN-1:0]   div_val, md_res;

  always_comb begin
    mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, d_q} : '0);
    div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, d_q};
    div_ge    = !div_diff[XLEN+1];
    if (op_q[2])
      p_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), p_q[XLEN-2:0], div_ge};
    else
      p_step = {mul_sum, p_q[XLEN-1:1]};

    // Sign correction applied to the final step's value.
    mul_full = neg_q ? ('0 - p_step) : p_step;
    div_val  = op_q[1] ? p_step[2*XLEN-1:XLEN] : p_step[XLEN-1:0];
    if (op_q[2])
      md_res = neg_q ? ('0 - div_val) : div_val;
    else
      md_res = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
  end
`else
  assign long_op = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = long_op ? ST_BUSY : ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = long_op ? ST_BUSY : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      ST_BUSY: begin
`ifdef ALU_ITER_MULDIV_EN
        if (cnt_q == CW'(1)) state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // -------------------------------------------------------------------------
  // Result and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the control state so a
  // reset mid-operation leaves no stale partial product visible afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      out_illegal <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
      cnt_q       <= '0;
      p_q         <= '0;
      d_q         <= '0;
      neg_q       <= 1'b0;
      op_q        <= '0;
`endif
    end else if (accept) begin
      if (m_sel) begin
`ifdef ALU_ITER_MULDIV_EN
        out_illegal <= 1'b0;
        if (div_fast) begin
          result <= fast_res;
        end else begin
          cnt_q <= CW'(XLEN);
          op_q  <= f3;
          neg_q <= (is_div && f3[1]) ? sa : (sa ^ sb);
          if (is_div) begin
            p_q <= {{XLEN{1'b0}}, ma};
            d_q <= mb;
          end else begin
            p_q <= {{XLEN{1'b0}}, mb};
            d_q <= ma;
          end
        end
`else
        result      <= '0;
        out_illegal <= 1'b1;
`endif
      end else begin
        result      <= base_res;
        out_illegal <= 1'b0;
      end
`ifdef ALU_ITER_MULDIV_EN
    end else if ((state_q == ST_BUSY) && !flush) begin
      p_q   <= p_step;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result <= md_res;
`endif
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// ---------------------------------------------------------------------------
// tb_alu_iter -- self-checking bench for alu_iter (XLEN=32). Directed cases
// for the documented corner values plus randomized ops compared against a
// plain-arithmetic reference model. Follows ALU_ITER_MULDIV_EN like the RTL.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_iter;
  import alu_iter_pkg::*;

`ifdef ALU_ITER_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        m_sel = 1'b0;
  logic [3:0]  operation = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        result_zero;
  logic        out_illegal;

  int n_total = 0;
  int n_pass  = 0;

  alu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .m_sel(m_sel), .operation(operation),
    .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_zero(result_zero), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: returns {illegal, result}.
  function automatic logic [32:0] model(input logic ms, input logic [3:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    if (!ms) begin
      case (op)
        ALU_ADD:  return {1'b0, a + b};
        ALU_SUB:  return {1'b0, a - b};
        ALU_SLL:  return {1'b0, a << b[4:0]};
        ALU_SLT:  return {1'b0, 32'(ia < ib)};
        ALU_SLTU: return {1'b0, 32'(a < b)};
        ALU_XOR:  return {1'b0, a ^ b};
        ALU_SRL:  return {1'b0, a >> b[4:0]};
        ALU_SRA:  return {1'b0, 32'(ia >>> b[4:0])};
        ALU_OR:   return {1'b0, a | b};
        ALU_AND:  return {1'b0, a & b};
        ALU_SEQ:  return {1'b0, 32'(a == b)};
        default:  return {1'b0, 32'd0};
      endcase
    end
    if (!MD_EN) return {1'b1, 32'd0};
    case (op[2:0])
      M_MUL:    begin p = sa * sb; return {1'b0, p[31:0]};  end
      M_MULH:   begin p = sa * sb; return {1'b0, p[63:32]}; end
      M_MULHSU: begin p = sa * ua; return {1'b0, p[63:32]}; end
      M_MULHU:  begin p = ua * ub; return {1'b0, p[63:32]}; end
      M_DIV: begin
        if (b == 0) return {1'b0, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a};
        return {1'b0, 32'(ia / ib)};
      end
      M_DIVU:   return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
      M_REM: begin
        if (b == 0) return {1'b0, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0};
        return {1'b0, 32'(ia % ib)};
      end
      default:  return {1'b0, (b == 0) ? a : a % b};
    endcase
  endfunction

  function automatic int model_lat(input logic ms, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
    if (!ms || !MD_EN) return 1;
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, measure accept-to-out_valid latency, check, consume.
  task automatic run(input logic ms, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic ei,
                     input int el, input string tag);
    int n;
    bit busy_rdy;
    @(negedge clk);
    in_valid = 1'b1; m_sel = ms; operation = op; operand_a = a; operand_b = b;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) check({tag, " accept"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    busy_rdy = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) busy_rdy = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(el));
    check({tag, " result"},  64'(result), 64'(er));
    check({tag, " illegal"}, 64'(out_illegal), 64'(ei));
    check({tag, " zero"},    64'(result_zero), 64'(er == 0));
    if (el > 1) check({tag, " in_ready busy"}, 64'(busy_rdy), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic ms, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [32:0] e;
    e = model(ms, op, a, b);
    run(ms, op, a, b, e[31:0], e[32], model_lat(ms, op, a, b), tag);
  endtask

  initial begin
    logic [32:0] e;
    logic [31:0] x, y;
    int          n;
    bit          bad;

    // Reset state
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst zero", 64'(result_zero), 64'd1);
    check("rst illegal", 64'(out_illegal), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Base ops
    run(1'b0, ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, "sra");
    run(1'b0, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, "sltu");
    run(1'b0, ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1, "sub zero");
    run(1'b0, ALU_NONE, 32'd7, 32'd9, 32'd0, 1'b0, 1, "none");

    // M ops
`ifdef ALU_ITER_MULDIV_EN
    run(1'b1, {1'b0, M_MULH},   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, "mulh");
    run(1'b1, {1'b0, M_MULHSU}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu");
    run(1'b1, {1'b0, M_DIV},    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div");
    run(1'b1, {1'b0, M_REM},    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, "rem");
    run(1'b1, {1'b0, M_DIVU},   32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, "divu0");
    run(1'b1, {1'b0, M_REM},    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, "rem ovf");
`else
    run(1'b1, {1'b0, M_MUL}, 32'd5, 32'd6, 32'd0, 1'b1, 1, "mul illegal");
`endif

    // Back-to-back base ops with out_ready high: one result per cycle
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom;
      operation = (i % 2 == 0) ? ALU_ADD : ALU_XOR;
      in_valid = 1'b1; m_sel = 1'b0; operand_a = x; operand_b = y;
      e = model(1'b0, operation, x, y);
      @(negedge clk);
      check("b2b valid", 64'(out_valid), 64'd1);
      check("b2b result", 64'(result), 64'(e[31:0]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure after a MUL, then ADD accepted in the release cycle
    x = $urandom; y = $urandom;
    e = model(1'b1, {1'b0, M_MUL}, x, y);
    @(negedge clk);
    in_valid = 1'b1; m_sel = 1'b1; operation = {1'b0, M_MUL}; operand_a = x; operand_b = y;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== e[31:0]) bad = 1'b1;
    end
    check("bp hold", 64'(bad), 64'd0);
    check("bp result", 64'(result), 64'(e[31:0]));
    out_ready = 1'b1;
    in_valid = 1'b1; m_sel = 1'b0; operation = ALU_ADD; operand_a = 32'd100; operand_b = 32'd23;
    #1 check("bp in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp add valid", 64'(out_valid), 64'd1);
    check("bp add result", 64'(result), 64'd123);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle", 64'(out_valid), 64'd0);

    // Flush of a held result; request in the flush cycle is refused
    @(negedge clk);
    in_valid = 1'b1; m_sel = 1'b0; operation = ALU_OR; operand_a = 32'h10; operand_b = 32'h1;
    @(negedge clk);
    flush = 1'b1;
    operation = ALU_ADD;
    #1 check("flush in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush drop", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("flush no accept", 64'(out_valid), 64'd0);

`ifdef ALU_ITER_MULDIV_EN
    // Flush at BUSY cycle 10 of a DIV; next request completes normally
    @(negedge clk);
    in_valid = 1'b1; m_sel = 1'b1; operation = {1'b0, M_DIV}; operand_a = 32'd1000; operand_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    bad = 1'b0;
    repeat (9) begin @(negedge clk); if (out_valid) bad = 1'b1; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if (out_valid) bad = 1'b1;
    check("busy flush", 64'(bad), 64'd0);
    run(1'b1, {1'b0, M_DIVU}, 32'd1000, 32'd7, 32'd142, 1'b0, 33, "after flush");

    // Async reset at BUSY cycle 20 of a MUL
    @(negedge clk);
    in_valid = 1'b1; m_sel = 1'b1; operation = {1'b0, M_MUL}; operand_a = 32'd123; operand_b = 32'd456;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
`else
    // Async reset with a held nonzero result
    @(negedge clk);
    in_valid = 1'b1; m_sel = 1'b0; operation = ALU_ADD; operand_a = 32'd9; operand_b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid", 64'(out_valid), 64'd0);
    check("async rst result", 64'(result), 64'd0);
    check("async rst zero", 64'(result_zero), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1, "post-rst add");

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      logic       ms;
      logic [3:0] op;
      ms = 1'($urandom_range(0, 1));
      op = ms ? {1'b0, 3'($urandom_range(0, 7))} : 4'($urandom_range(0, 15));
      do_op(ms, op, pick_operand(), pick_operand(), $sformatf("rnd%0d m%0d op%0d", i, ms, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
